blit_read_split: RTL and testbench
==================================

Name: blit_read_split

Overview:
- Read-side counterpart of the blitter's byte-to-word write merge.
- Accepts a stream of byte-addressed source reads from the blit address stage (p2).
- Fetches aligned 32-bit words from memory, holding the last fetched word in a one-word buffer.
- Delivers one byte per request to the next blit stage (p3), so consecutive bytes in the same word cost a single memory read.

Parameters:
- none; address width is fixed at 26 bits, data at 32 bits, byte lanes little-endian.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- p2_addr  in  26  byte address of the source read
- p2_valid  in  1  request present
- p2_ready  out  1  request accepted when p2_valid && p2_ready
- invalidate  in  1  drop buffered word (memory may have been written)
- mem_req  out  1  word read request
- mem_addr  out  26  word address, bits [1:0] always 0
- mem_ack  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data
- p3_data  out  8  selected byte
- p3_valid  out  1  byte valid
- p3_stall  in  1  downstream cannot take p3 this cycle
- p3_idle  out  1  no request in flight and p3 empty

Behaviour:
- State: state ∈ {IDLE, REQ, WAIT, EMIT}, buf_addr[25:2], buf_data[31:0], buf_valid, req_addr[25:0], keep_flag.
- Reset (async): state=IDLE, buf_valid=0, buf_addr=0, mem_req=0, mem_addr=0, p3_valid=0, p3_data=0, keep_flag=0.
- out_free = !(p3_valid && p3_stall). While stalled, p3_data and p3_valid hold unchanged.
- p3_valid clears on a non-stalled cycle with no new byte.
- p2_ready = (state==IDLE) && out_free.
- Byte select by addr[1:0]: 0 -> [7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24].
- Hit (accept with buf_valid && p2_addr[25:2]==buf_addr and no invalidate this cycle):
  - p3_data is the selected byte and p3_valid=1 on the next edge.
  - One request per cycle sustained.
- Miss (any other accept):
  - Latch req_addr.
  - Next edge: state=REQ, mem_req=1, mem_addr={p2_addr[25:2],2'b00}.
- REQ:
  - mem_req and mem_addr stay stable until mem_ack.
  - On mem_ack: mem_req=0 next edge, go WAIT.
  - If mem_rvalid arrives in the same cycle as mem_ack, treat it as the WAIT response below.
- WAIT, on mem_rvalid:
  - buf_data=mem_rdata, buf_addr=req_addr[25:2].
  - buf_valid = !keep_flag && !invalidate.
  - If out_free: p3 loads the byte of mem_rdata at req_addr[1:0], go IDLE.
  - Else: go EMIT.
  - Miss latency: accept at cycle N, mem_req at N+1; if ack at N+1 and rvalid at N+1+L, p3_valid at N+2+L.
- EMIT: when out_free, load the byte from buf_data, go IDLE.
- invalidate:
  - In IDLE, clears buf_valid next edge.
  - A request accepted in the same cycle is treated as a miss.
  - During REQ or WAIT, sets keep_flag so the returning word serves the pending byte but is not retained.
  - keep_flag clears on return to IDLE.
- mem_rvalid in IDLE or EMIT is ignored. This covers responses to a request in flight at reset.
- mem_ack without mem_req is ignored.
- p3_idle = (state==IDLE) && !p3_valid.
- Timing: no combinational path from mem_* inputs to p2_ready or mem_req. p2_ready may depend combinationally on p3_stall.

Test Plan:
- Sequential hits:
  - Stimulus: after reset, read 0x000100, then 0x000101, 0x000102, 0x000103; memory returns 0xDDCCBBAA.
  - Response: exactly one mem_req with mem_addr=0x000100; p3_data = AA, BB, CC, DD on consecutive cycles.
- Word crossing:
  - Stimulus: read 0x000103, then 0x000104; memory returns 0x11223344, then 0x55667788.
  - Response: two memory reads (0x000100, 0x000104); p3_data = 0x11, then 0x88.
- Delayed ack and stall:
  - Stimulus: hold mem_ack low 3 cycles; mem_rvalid arrives while p3_stall=1.
  - Response: mem_addr stable throughout, state passes through EMIT, p3 byte appears only after stall drops, p2_ready low meanwhile.
- Invalidate:
  - Stimulus: read 0x000200 (word 0xA0B0C0D0) and pulse invalidate; re-read 0x000201.
  - Response: a second mem_req is issued.
  - Stimulus: pulse invalidate during WAIT.
  - Response: the byte is still delivered, and the next same-word read misses.
- Ack with data:
  - Stimulus: mem_ack and mem_rvalid in the same cycle.
  - Response: byte delivered the following cycle, no hang in WAIT.
- Reset mid-operation:
  - Stimulus: assert reset during WAIT; a stray mem_rvalid arrives after release.
  - Response: all outputs are 0 immediately, the stray mem_rvalid is ignored, p3_idle=1, and the first post-reset read misses.

Source files
------------

// File: rtl/blit_read_split.sv
// blit_read_split: read-side byte splitter for the blitter source path.
// Takes byte-addressed reads from p2, fetches aligned 32-bit words from memory
// into a one-word buffer, and hands one byte per request to p3. Bytes that share
// the buffered word are served without another memory read.

module blit_read_split (
   input  logic        clock,
   input  logic        reset,
   input  logic [25:0] p2_addr,
   input  logic        p2_valid,
   output logic        p2_ready,
   input  logic        invalidate,
   output logic        mem_req,
   output logic [25:0] mem_addr,
   input  logic        mem_ack,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [7:0]  p3_data,
   output logic        p3_valid,
   input  logic        p3_stall,
   output logic        p3_idle
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      EMIT = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [23:0] buf_addr_q, buf_addr_d;
   logic [31:0] buf_data_q, buf_data_d;
   logic        buf_valid_q, buf_valid_d;
   logic [25:0] req_addr_q, req_addr_d;
   logic        keep_q, keep_d;
   logic        mem_req_q, mem_req_d;
   logic [25:0] mem_addr_q, mem_addr_d;
   logic        p3_valid_q, p3_valid_d;
   logic [7:0]  p3_data_q, p3_data_d;

   logic out_free;
   logic accept;
   logic hit;
   logic take_word;

   // Little-endian byte lane select within a 32-bit word.
   function automatic logic [7:0] lane(input logic [31:0] word, input logic [1:0] sel);
      return word[{sel, 3'b000} +: 8];
   endfunction

   // p3 can take a new byte unless it is currently holding one against a stall.
   assign out_free = !(p3_valid_q && p3_stall);
   assign p2_ready = (state_q == IDLE) && out_free;
   assign accept   = p2_valid && p2_ready;
   assign hit      = buf_valid_q && (p2_addr[25:2] == buf_addr_q) && !invalidate;

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign p3_data  = p3_data_q;
   assign p3_valid = p3_valid_q;
   assign p3_idle  = (state_q == IDLE) && !p3_valid_q;

   // Next-state logic: request acceptance, memory handshake and p3 loading.
   always_comb begin
      // NOTE: every _d starts from its _q so no path through this block infers a latch.
      state_d     = state_q;
      buf_addr_d  = buf_addr_q;
      buf_data_d  = buf_data_q;
      buf_valid_d = buf_valid_q;
      req_addr_d  = req_addr_q;
      keep_d      = keep_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      p3_valid_d  = p3_valid_q;
      p3_data_d   = p3_data_q;
      take_word   = 1'b0;

      // A byte that was taken this cycle drops unless replaced below; a stalled
      // byte holds both data and valid.
      if (out_free) begin
         p3_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            keep_d = 1'b0;
            if (invalidate) begin
               buf_valid_d = 1'b0;
            end
            if (accept) begin
               if (hit) begin
                  p3_data_d  = lane(buf_data_q, p2_addr[1:0]);
                  p3_valid_d = 1'b1;
               end else begin
                  req_addr_d = p2_addr;
                  mem_req_d  = 1'b1;
                  mem_addr_d = {p2_addr[25:2], 2'b00};
                  state_d    = REQ;
               end
            end
         end

         REQ: begin
            if (invalidate) begin
               keep_d = 1'b1;
            end
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = WAIT;
               // Data returning alongside the ack is handled exactly as in WAIT.
               take_word = mem_rvalid;
            end
         end

         WAIT: begin
            if (invalidate) begin
               keep_d = 1'b1;
            end
            take_word = mem_rvalid;
         end

         EMIT: begin
            if (invalidate) begin
               buf_valid_d = 1'b0;
            end
            if (out_free) begin
               p3_data_d  = lane(buf_data_q, req_addr_q[1:0]);
               p3_valid_d = 1'b1;
               keep_d     = 1'b0;
               state_d    = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Returned word: always serves the pending byte, retained only if no
      // invalidate was seen while the read was in flight.
      if (take_word) begin
         buf_data_d  = mem_rdata;
         buf_addr_d  = req_addr_q[25:2];
         buf_valid_d = !keep_q && !invalidate;
         if (out_free) begin
            p3_data_d  = lane(mem_rdata, req_addr_q[1:0]);
            p3_valid_d = 1'b1;
            keep_d     = 1'b0;
            state_d    = IDLE;
         end else begin
            state_d = EMIT;
         end
      end
   end

   // State register with asynchronous active-high reset.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q     <= IDLE;
         buf_addr_q  <= '0;
         // NOTE: the word buffer is cleared too; buf_valid already gates it, this only keeps X out.
         buf_data_q  <= '0;
         buf_valid_q <= 1'b0;
         req_addr_q  <= '0;
         keep_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         p3_valid_q  <= 1'b0;
         p3_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         buf_addr_q  <= buf_addr_d;
         buf_data_q  <= buf_data_d;
         buf_valid_q <= buf_valid_d;
         req_addr_q  <= req_addr_d;
         keep_q      <= keep_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         p3_valid_q  <= p3_valid_d;
         p3_data_q   <= p3_data_d;
      end
   end

endmodule

// File: tb/tb_blit_read_split.sv
// Testbench for blit_read_split: directed scenarios plus a randomized run
// scored against a word-cache reference model.
`timescale 1ns/1ps

module tb_blit_read_split;

   logic        clock;
   logic        reset;
   logic [25:0] p2_addr;
   logic        p2_valid;
   logic        p2_ready;
   logic        invalidate;
   logic        mem_req;
   logic [25:0] mem_addr;
   logic        mem_ack;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [7:0]  p3_data;
   logic        p3_valid;
   logic        p3_stall;
   logic        p3_idle;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   blit_read_split dut (
      .clock      (clock),
      .reset      (reset),
      .p2_addr    (p2_addr),
      .p2_valid   (p2_valid),
      .p2_ready   (p2_ready),
      .invalidate (invalidate),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .p3_data    (p3_data),
      .p3_valid   (p3_valid),
      .p3_stall   (p3_stall),
      .p3_idle    (p3_idle)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Memory contents: per-test overrides, otherwise an address hash.
   logic [31:0] mem_ovr [int];

   function automatic logic [31:0] mem_word(input logic [25:0] a);
      int w;
      w = int'(a[25:2]);
      if (mem_ovr.exists(w)) return mem_ovr[w];
      return {a[9:2] ^ 8'h3C, a[17:10] ^ 8'hA5, a[9:2] + 8'h11, a[25:18] ^ a[9:2]};
   endfunction

   function automatic logic [7:0] exp_byte(input logic [25:0] a);
      logic [31:0] w;
      w = mem_word(a);
      case (a[1:0])
         2'd0:    return w[7:0];
         2'd1:    return w[15:8];
         2'd2:    return w[23:16];
         default: return w[31:24];
      endcase
   endfunction

   // Monitors: bytes taken by p3 and memory requests accepted.
   logic [7:0]  got_q [$];
   int          got_cyc [$];
   logic [25:0] ack_q [$];

   always @(negedge clock) begin
      if (!reset && p3_valid && !p3_stall) begin
         got_q.push_back(p3_data);
         got_cyc.push_back(cyc);
      end
      if (!reset && mem_req && mem_ack) ack_q.push_back(mem_addr);
   end

   // Memory responder: ack after ack_dly waiting cycles, data rv_dly cycles after ack.
   int ack_dly  = 0;
   int rv_dly   = 1;
   bit rand_dly = 0;
   bit resp_en  = 1;

   initial begin : responder
      int wait_n;
      int rv_n;
      bit pend;
      bit fresh;
      logic [25:0] pa;
      mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      wait_n = 0; rv_n = 0; pend = 0; fresh = 1; pa = '0;
      forever begin
         @(posedge clock); #1;
         if (reset || !resp_en) begin
            pend = 0; fresh = 1; wait_n = 0;
            if (reset) begin mem_ack = 1'b0; mem_rvalid = 1'b0; end
         end else begin
            mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (pend) begin
               if (rv_n == 0) begin mem_rvalid = 1'b1; mem_rdata = mem_word(pa); pend = 0; end
               else rv_n--;
            end else if (mem_req) begin
               if (fresh && rand_dly) begin
                  ack_dly = $urandom_range(0, 3);
                  rv_dly  = $urandom_range(0, 3);
               end
               fresh = 0;
               if (wait_n >= ack_dly) begin
                  mem_ack = 1'b1; wait_n = 0; fresh = 1;
                  if (rv_dly == 0) begin mem_rvalid = 1'b1; mem_rdata = mem_word(mem_addr); end
                  else begin pend = 1; rv_n = rv_dly - 1; pa = mem_addr; end
               end else wait_n++;
            end
         end
      end
   end

   task automatic step();
      @(posedge clock); #1;
   endtask

   task automatic sample();
      @(negedge clock); #1;
   endtask

   task automatic apply_reset();
      p2_valid = 1'b0; p2_addr = '0; invalidate = 1'b0; p3_stall = 1'b0;
      @(negedge clock); reset = 1'b1;
      @(negedge clock); reset = 1'b0;
      step();
      got_q.delete(); got_cyc.delete(); ack_q.delete(); mem_ovr.delete();
      ack_dly = 0; rv_dly = 1; rand_dly = 0; resp_en = 1;
   endtask

   // Present one request and return the cycle it was accepted; p2_valid is left high.
   task automatic issue(input logic [25:0] a, input logic inv, output int acc);
      int n;
      n = 0; acc = -1;
      p2_valid = 1'b1; p2_addr = a; invalidate = inv;
      while (acc < 0 && n < 200) begin
         sample();
         if (p2_ready) acc = cyc;
         else begin step(); n++; end
      end
      if (acc < 0) begin $display("FAIL issue_timeout addr=%h never accepted", a); errors++; end
      checks++;
      step();
      invalidate = 1'b0;
   endtask

   task automatic wait_bytes(input int n);
      for (int k = 0; k < 300 && got_q.size() < n; k++) step();
      if (got_q.size() < n) begin
         $display("FAIL byte_timeout got=%0d bytes want=%0d", got_q.size(), n); errors++;
      end
      checks++;
   endtask

   task automatic test_reset();
      reset = 1'b1; p2_valid = 1'b0; p2_addr = '0; invalidate = 1'b0; p3_stall = 1'b0;
      step(); step(); sample();
      if (mem_req !== 1'b0) begin $display("FAIL reset_mem_req got=%b want=0", mem_req); errors++; end
      checks++;
      if (mem_addr !== 26'h0) begin $display("FAIL reset_mem_addr got=%h want=0", mem_addr); errors++; end
      checks++;
      if (p3_valid !== 1'b0 || p3_data !== 8'h00) begin
         $display("FAIL reset_p3 got valid=%b data=%h want 0/00", p3_valid, p3_data); errors++;
      end
      checks++;
      if (p3_idle !== 1'b1 || p2_ready !== 1'b1) begin
         $display("FAIL reset_idle got idle=%b ready=%b want 1/1", p3_idle, p2_ready); errors++;
      end
      checks++;
      @(negedge clock); reset = 1'b0;
      step();
   endtask

   task automatic test_sequential_hits();
      int a0, a1, a2, a3;
      logic [7:0] want [4];
      apply_reset();
      mem_ovr['h40] = 32'hDDCCBBAA; rv_dly = 2;
      want[0] = 8'hAA; want[1] = 8'hBB; want[2] = 8'hCC; want[3] = 8'hDD;
      issue(26'h000100, 1'b0, a0);
      issue(26'h000101, 1'b0, a1);
      issue(26'h000102, 1'b0, a2);
      issue(26'h000103, 1'b0, a3);
      p2_valid = 1'b0;
      wait_bytes(4);
      if (ack_q.size() != 1 || ack_q[0] !== 26'h000100) begin
         $display("FAIL seq_mem_reads got count=%0d first=%h want 1 at 000100", ack_q.size(),
                  ack_q.size() > 0 ? ack_q[0] : 26'h0);
         errors++;
      end
      checks++;
      for (int i = 0; i < 4; i++) begin
         if (got_q[i] !== want[i]) begin $display("FAIL seq_byte%0d got=%h want=%h", i, got_q[i], want[i]); errors++; end
         checks++;
      end
      if (got_cyc[0] != a0 + 4) begin $display("FAIL seq_miss_latency got=%0d want=%0d", got_cyc[0] - a0, 4); errors++; end
      checks++;
      if (a1 != a0 + 4 || a2 != a1 + 1 || a3 != a2 + 1 || got_cyc[3] != got_cyc[0] + 3) begin
         $display("FAIL seq_back_to_back got accepts %0d,%0d,%0d,%0d bytes last=%0d", a0, a1, a2, a3, got_cyc[3]);
         errors++;
      end
      checks++;
   endtask

   task automatic test_word_crossing();
      int acc;
      apply_reset();
      mem_ovr['h40] = 32'h11223344; mem_ovr['h41] = 32'h55667788;
      issue(26'h000103, 1'b0, acc);
      issue(26'h000104, 1'b0, acc);
      p2_valid = 1'b0;
      wait_bytes(2);
      if (ack_q.size() != 2 || ack_q[0] !== 26'h000100 || ack_q[1] !== 26'h000104) begin
         $display("FAIL cross_mem_reads got count=%0d want 2 (000100,000104)", ack_q.size()); errors++;
      end
      checks++;
      if (got_q[0] !== 8'h11 || got_q[1] !== 8'h88) begin
         $display("FAIL cross_bytes got=%h,%h want=11,88", got_q[0], got_q[1]); errors++;
      end
      checks++;
   endtask

   task automatic test_delayed_ack_stall();
      int acc, nreq;
      logic [25:0] a;
      logic [7:0] want, first_data;
      bit seen;
      apply_reset();
      ack_dly = 3; rv_dly = 2; a = 26'h000345; want = exp_byte(a);
      issue(a, 1'b0, acc);
      p2_valid = 1'b0; p3_stall = 1'b1; nreq = 0; seen = 0; first_data = '0;
      for (int k = 0; k < 12; k++) begin
         sample();
         if (mem_req) begin
            nreq++;
            if (mem_addr !== {a[25:2], 2'b00}) begin
               $display("FAIL stall_mem_addr got=%h want=%h", mem_addr, {a[25:2], 2'b00}); errors++;
            end
            checks++;
         end
         if (p2_ready !== 1'b0) begin $display("FAIL stall_p2_ready cycle %0d got=%b want=0", k, p2_ready); errors++; end
         checks++;
         if (p3_valid && !seen) begin seen = 1; first_data = p3_data; end
         step();
      end
      if (nreq != 4) begin $display("FAIL stall_req_cycles got=%0d want=4", nreq); errors++; end
      checks++;
      if (got_q.size() != 0) begin $display("FAIL stall_early_byte got=%0d bytes want=0", got_q.size()); errors++; end
      checks++;
      if (p3_valid !== 1'b1 || p3_data !== want || first_data !== want || p3_idle !== 1'b0) begin
         $display("FAIL stall_hold got valid=%b data=%h first=%h idle=%b want 1/%h/%h/0",
                  p3_valid, p3_data, first_data, p3_idle, want, want);
         errors++;
      end
      checks++;
      p3_stall = 1'b0;
      sample();
      if (got_q.size() != 1 || got_q[0] !== want) begin
         $display("FAIL stall_release got=%0d bytes want 1 byte %h", got_q.size(), want); errors++;
      end
      checks++;
      step(); sample();
      if (p3_valid !== 1'b0 || p3_idle !== 1'b1 || p2_ready !== 1'b1) begin
         $display("FAIL stall_after got valid=%b idle=%b ready=%b want 0/1/1", p3_valid, p3_idle, p2_ready); errors++;
      end
      checks++;
      step();
   endtask

   task automatic test_invalidate();
      int acc;
      apply_reset();
      mem_ovr['h80] = 32'hA0B0C0D0;
      issue(26'h000200, 1'b0, acc); p2_valid = 1'b0; wait_bytes(1);
      invalidate = 1'b1; step(); invalidate = 1'b0;
      issue(26'h000201, 1'b0, acc); p2_valid = 1'b0; wait_bytes(2);
      if (ack_q.size() != 2 || got_q[1] !== 8'hC0) begin
         $display("FAIL inv_idle got reads=%0d byte=%h want 2/C0", ack_q.size(), got_q[1]); errors++;
      end
      checks++;
      issue(26'h000202, 1'b1, acc); p2_valid = 1'b0; wait_bytes(3);
      if (ack_q.size() != 3 || got_q[2] !== 8'hB0) begin
         $display("FAIL inv_same_cycle got reads=%0d byte=%h want 3/B0", ack_q.size(), got_q[2]); errors++;
      end
      checks++;
      issue(26'h000203, 1'b0, acc); p2_valid = 1'b0; wait_bytes(4);
      if (ack_q.size() != 3 || got_q[3] !== 8'hA0) begin
         $display("FAIL inv_refill_hit got reads=%0d byte=%h want 3/A0", ack_q.size(), got_q[3]); errors++;
      end
      checks++;
      rv_dly = 4;
      issue(26'h0002F1, 1'b0, acc); p2_valid = 1'b0;
      step();
      invalidate = 1'b1; step(); invalidate = 1'b0;
      wait_bytes(5);
      if (ack_q.size() != 4 || got_q[4] !== exp_byte(26'h0002F1)) begin
         $display("FAIL inv_wait_deliver got reads=%0d byte=%h want 4/%h", ack_q.size(), got_q[4], exp_byte(26'h0002F1));
         errors++;
      end
      checks++;
      issue(26'h0002F2, 1'b0, acc); p2_valid = 1'b0; wait_bytes(6);
      if (ack_q.size() != 5 || got_q[5] !== exp_byte(26'h0002F2) || acc < 0) begin
         $display("FAIL inv_wait_not_kept got reads=%0d byte=%h want 5/%h", ack_q.size(), got_q[5], exp_byte(26'h0002F2));
         errors++;
      end
      checks++;
   endtask

   task automatic test_ack_with_data();
      int acc;
      logic [25:0] a;
      apply_reset();
      ack_dly = 1; rv_dly = 0; a = 26'h0001A7;
      issue(a, 1'b0, acc); p2_valid = 1'b0;
      wait_bytes(1);
      if (got_q[0] !== exp_byte(a) || got_cyc[0] != acc + 3) begin
         $display("FAIL ackdata_byte got=%h at +%0d want=%h at +3", got_q[0], got_cyc[0] - acc, exp_byte(a)); errors++;
      end
      checks++;
      sample();
      if (p3_idle !== 1'b1 || p2_ready !== 1'b1) begin
         $display("FAIL ackdata_no_hang got idle=%b ready=%b want 1/1", p3_idle, p2_ready); errors++;
      end
      checks++;
      step();
      issue(26'h0001A4, 1'b0, acc); p2_valid = 1'b0; wait_bytes(2);
      if (ack_q.size() != 1 || got_q[1] !== exp_byte(26'h0001A4)) begin
         $display("FAIL ackdata_kept got reads=%0d byte=%h want 1/%h", ack_q.size(), got_q[1], exp_byte(26'h0001A4));
         errors++;
      end
      checks++;
   endtask

   task automatic test_reset_mid();
      int acc, n0;
      apply_reset();
      issue(26'h0003C2, 1'b0, acc); p2_valid = 1'b0; wait_bytes(1);
      sample(); resp_en = 0; step();
      mem_ack = 1'b0; mem_rvalid = 1'b0;
      issue(26'h0005E1, 1'b0, acc); p2_valid = 1'b0;
      mem_ack = 1'b1; step(); mem_ack = 1'b0;
      #2; reset = 1'b1; #1;
      if (mem_req !== 1'b0 || mem_addr !== 26'h0 || p3_valid !== 1'b0 || p3_data !== 8'h00 || p3_idle !== 1'b1) begin
         $display("FAIL midreset_outputs got req=%b addr=%h valid=%b data=%h idle=%b want 0/0/0/00/1",
                  mem_req, mem_addr, p3_valid, p3_data, p3_idle);
         errors++;
      end
      checks++;
      @(negedge clock); reset = 1'b0;
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      step(); mem_rvalid = 1'b0; sample();
      if (p3_valid !== 1'b0 || p3_idle !== 1'b1 || mem_req !== 1'b0) begin
         $display("FAIL midreset_stray got valid=%b idle=%b req=%b want 0/1/0", p3_valid, p3_idle, mem_req); errors++;
      end
      checks++;
      n0 = ack_q.size(); resp_en = 1; step();
      issue(26'h0005E1, 1'b0, acc); p2_valid = 1'b0; wait_bytes(2);
      if (ack_q.size() != n0 + 1 || got_q[got_q.size() - 1] !== exp_byte(26'h0005E1)) begin
         $display("FAIL midreset_first_miss got reads=%0d want=%0d", ack_q.size() - n0, 1); errors++;
      end
      checks++;
   endtask

   task automatic test_random();
      bit mv, pend, dirty, acc_now, was_stalled;
      logic [23:0] mtag, ptag;
      logic [7:0] held;
      logic [7:0] exp_q [$];
      int exp_miss, n_acc, bad;
      apply_reset();
      rand_dly = 1;
      mv = 0; pend = 0; dirty = 0; mtag = '0; ptag = '0; held = '0; was_stalled = 0;
      exp_miss = 0; n_acc = 0;
      for (int c = 0; c < 3000 && n_acc < 400; c++) begin
         p2_valid   = ($urandom_range(0, 9) < 7);
         p2_addr    = 26'h010000 | 26'($urandom_range(0, 23));
         invalidate = ($urandom_range(0, 19) == 0);
         p3_stall   = ($urandom_range(0, 3) == 0);
         sample();
         if (was_stalled) begin
            if (p3_valid !== 1'b1 || p3_data !== held) begin
               $display("FAIL rand_stall_hold got valid=%b data=%h want 1/%h", p3_valid, p3_data, held); errors++;
            end
            checks++;
         end
         was_stalled = p3_valid && p3_stall;
         held = p3_data;
         acc_now = p2_valid && p2_ready;
         if (pend) begin
            if (invalidate) dirty = 1;
            if (mem_rvalid) begin mv = !dirty; mtag = ptag; pend = 0; end
         end else if (invalidate) mv = 0;
         if (acc_now) begin
            exp_q.push_back(exp_byte(p2_addr)); n_acc++;
            if (!(mv && mtag == p2_addr[25:2] && !invalidate)) begin
               exp_miss++; pend = 1; dirty = 0; ptag = p2_addr[25:2];
            end
         end
         step();
      end
      p2_valid = 1'b0; invalidate = 1'b0; p3_stall = 1'b0;
      repeat (40) step();
      if (got_q.size() != exp_q.size()) begin
         $display("FAIL rand_byte_count got=%0d want=%0d", got_q.size(), exp_q.size()); errors++;
      end
      checks++;
      bad = 0;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
      if (bad != 0) begin $display("FAIL rand_bytes got %0d wrong bytes want 0", bad); errors++; end
      checks++;
      if (ack_q.size() != exp_miss) begin
         $display("FAIL rand_mem_reads got=%0d want=%0d", ack_q.size(), exp_miss); errors++;
      end
      checks++;
      sample();
      if (p3_idle !== 1'b1) begin $display("FAIL rand_drain_idle got=%b want=1", p3_idle); errors++; end
      checks++;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin : main
      reset = 1'b1; p2_valid = 1'b0; p2_addr = '0; invalidate = 1'b0; p3_stall = 1'b0;
      test_reset();
      test_sequential_hits();
      test_word_crossing();
      test_delayed_ack_stall();
      test_invalidate();
      test_ack_with_data();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
